// File: rtl/hasti_sram_slave_if.sv
// AHB-Lite (HASTI) signal bundle for one SRAM slave port.
// The master modport is the fabric side: it also drives the muxed bus-level hready.
interface hasti_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/hasti_sram_slave.sv
// AHB-Lite SRAM responder: byte-writable word array, configurable wait states,
// two-cycle ERROR response for illegal transfers, write-to-read forwarding.
module hasti_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic               hclk,
    input logic               hresetn,
    hasti_sram_slave_if.slave bus
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          dp_write_q, dp_write_d;
    logic [AW-1:0] dp_word_q, dp_word_d;
    logic [3:0]    dp_lanes_q, dp_lanes_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          completing, accept, legal, commit;
    logic [AW-1:0] addr_word;
    logic [3:0]    addr_lanes;
    logic [31:0]   fwd_rd;

    logic unused_inputs;
    assign unused_inputs = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.haddr[31:AW+2]};

    // Address-phase decode: legality and little-endian byte lanes.
    always_comb begin
        addr_word  = bus.haddr[AW+1:2];
        legal      = 1'b0;
        addr_lanes = 4'b0000;
        case (bus.hsize)
            3'd0: begin
                legal      = 1'b1;
                addr_lanes = 4'b0001 << bus.haddr[1:0];
            end
            3'd1: begin
                legal      = ~bus.haddr[0];
                addr_lanes = bus.haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal      = (bus.haddr[1:0] == 2'b00);
                addr_lanes = 4'b1111;
            end
            default: ;
        endcase
    end

    // Completion cycles are the only ones that can end a data phase and start the next.
    assign completing = (state_q == StIdle) || (state_q == StErr2) ||
                        ((state_q == StWait) && (cnt_q == 4'd0));
    assign accept     = bus.hsel & bus.hready & bus.htrans[1] & completing;
    assign commit     = completing & dp_write_q;

    // Read word with any bytes being committed on this same edge substituted in.
    always_comb begin
        fwd_rd = mem[addr_word];
        for (int k = 0; k < 4; k++) begin
            if (commit && (dp_word_q == addr_word) && dp_lanes_q[k]) begin
                fwd_rd[8*k +: 8] = bus.hwdata[8*k +: 8];
            end
        end
        rdata_d = (accept && legal && !bus.hwrite) ? fwd_rd : rdata_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_write_d = dp_write_q;
        dp_word_d  = dp_word_q;
        dp_lanes_d = dp_lanes_q;
        unique case (state_q)
            StErr1: state_d = StErr2;
            StIdle, StWait, StErr2: begin
                if (!completing) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = StIdle;
                    cnt_d      = 4'd0;
                    dp_write_d = 1'b0;
                    if (accept) begin
                        if (legal) begin
                            dp_write_d = bus.hwrite;
                            dp_word_d  = addr_word;
                            dp_lanes_d = addr_lanes;
                            if (WAIT_STATES != 0) begin
                                state_d = StWait;
                                cnt_d   = WAIT_INIT;
                            end
                        end else begin
                            state_d = StErr1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            dp_write_q <= 1'b0;
            dp_word_q  <= '0;
            dp_lanes_q <= 4'b0000;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_write_q <= dp_write_d;
            dp_word_q  <= dp_word_d;
            dp_lanes_q <= dp_lanes_d;
            rdata_q    <= rdata_d;
        end
    end

    // Array has no reset; a write pending when reset hits is simply dropped.
    always_ff @(posedge hclk) begin
        if (hresetn && commit) begin
            for (int k = 0; k < 4; k++) begin
                if (dp_lanes_q[k]) begin
                    mem[dp_word_q][8*k +: 8] <= bus.hwdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = completing;
    assign bus.hresp     = (state_q == StErr1) || (state_q == StErr2);
    assign bus.hrdata    = rdata_q;
endmodule

// File: tb/tb_hasti_sram_slave.sv
// Bench for hasti_sram_slave: directed vector table plus randomized pipelined traffic
// on three instances (0, 3 and 2 wait states) checked against a transaction-level model.
module tb_hasti_sram_slave;
    localparam int unsigned DEPTH = 16;
    localparam int NDUT = 3;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        logic        wresp;
        int          waits;
    } res_t;

    typedef struct {
        int          g;
        xfer_t       x;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_resp;
        int          exp_waits;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [NDUT];
    logic        sel_v   [NDUT];
    logic [1:0]  trans_v [NDUT];
    logic [31:0] addr_v  [NDUT];
    logic        wr_v    [NDUT];
    logic [2:0]  size_v  [NDUT];
    logic [2:0]  burst_v [NDUT];
    logic [3:0]  prot_v  [NDUT];
    logic        lock_v  [NDUT];
    logic [31:0] wdata_v [NDUT];
    logic        stall_v [NDUT];
    logic        ro_v    [NDUT];
    logic        resp_v  [NDUT];
    logic [31:0] rd_v    [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 3 : 2;
        hasti_sram_slave_if bus ();
        assign bus.hsel      = sel_v[g];
        assign bus.htrans    = trans_v[g];
        assign bus.haddr     = addr_v[g];
        assign bus.hwrite    = wr_v[g];
        assign bus.hsize     = size_v[g];
        assign bus.hburst    = burst_v[g];
        assign bus.hprot     = prot_v[g];
        assign bus.hmastlock = lock_v[g];
        assign bus.hwdata    = wdata_v[g];
        assign bus.hready    = bus.hreadyout & ~stall_v[g];
        assign ro_v[g]       = bus.hreadyout;
        assign resp_v[g]     = bus.hresp;
        assign rd_v[g]       = bus.hrdata;
        hasti_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
            .hclk   (clk),
            .hresetn(rst_n[g]),
            .bus    (bus)
        );
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          stall_en = 1'b0;
    xfer_t       xq[$];
    res_t        rq[$];
    vec_t        tab[$];
    logic [31:0] mem_m  [NDUT][DEPTH];
    logic [31:0] last_m [NDUT];

    function automatic int ws_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 3 : 2;
    endfunction

    function automatic bit legal_m(input logic [2:0] sz, input logic [31:0] a);
        return (sz == 3'd0) || (sz == 3'd1 && a[0] == 1'b0) || (sz == 3'd2 && a[1:0] == 2'b00);
    endfunction

    function automatic bit lane_m(input logic [2:0] sz, input logic [31:0] a, input int k);
        return (sz == 3'd2) || (sz == 3'd1 && (k / 2) == int'(a[1])) ||
               (sz == 3'd0 && k == int'(a[1:0]));
    endfunction

    function automatic xfer_t mkx(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                                  input logic [2:0] sz, input logic [31:0] wd);
        xfer_t x;
        x.sel = 1'b1; x.trans = tr; x.addr = a; x.wr = wr; x.size = sz; x.wdata = wd;
        return x;
    endfunction

    function automatic vec_t mkv(input int g, input xfer_t x, input logic chk,
                                 input logic [31:0] erd, input logic eresp, input int ew);
        vec_t v;
        v.g = g; v.x = x; v.chk = chk; v.exp_rd = erd; v.exp_resp = eresp; v.exp_waits = ew;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input int g, input bit ap_v, input xfer_t ap, input bit dp_v,
                         input xfer_t dp);
        sel_v[g]   = ap_v ? ap.sel : 1'b0;
        trans_v[g] = ap_v ? ap.trans : 2'b00;
        addr_v[g]  = ap.addr;
        wr_v[g]    = ap.wr;
        size_v[g]  = ap.size;
        burst_v[g] = 3'($urandom_range(7));
        prot_v[g]  = 4'($urandom_range(15));
        lock_v[g]  = 1'($urandom_range(1));
        wdata_v[g] = dp_v ? dp.wdata : $urandom;
    endtask

    // Pipelined master: presents xq back to back, one result per transfer into rq.
    task automatic run_stream(input int g);
        xfer_t ap, dp;
        res_t  res;
        bit    ap_v, dp_v, r;
        int    nxt, cyc, waits;
        logic  wresp;
        ap = mkx(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
        dp = ap;
        ap_v = 0; dp_v = 0; nxt = 0; cyc = 0; waits = 0; wresp = 1'b0;
        rq.delete();
        forever begin
            drive(g, ap_v, ap, dp_v, dp);
            @(negedge clk);
            r = ro_v[g] & ~stall_v[g];
            if (dp_v) begin
                if (r) begin
                    res.rdata = rd_v[g]; res.resp = resp_v[g];
                    res.wresp = wresp;   res.waits = waits;
                    rq.push_back(res);
                    dp_v = 0;
                end else begin
                    waits++;
                    wresp = wresp | resp_v[g];
                end
            end
            @(posedge clk);
            #1;
            if (r) begin
                if (ap_v) begin
                    dp = ap; dp_v = 1; waits = 0; wresp = 1'b0;
                end
                if (nxt < xq.size()) begin
                    ap = xq[nxt]; ap_v = 1; nxt++;
                end else begin
                    ap_v = 0;
                end
            end
            // Another slave may only hold hready low while this one has no data phase.
            stall_v[g] = stall_en && !dp_v && ($urandom_range(3) == 0);
            if (!ap_v && !dp_v && nxt >= xq.size()) break;
            cyc++;
            if (cyc > 4000) begin
                n_tests++; n_fail++;
                $display("FAIL stream_timeout dut%0d: got %0d results, expected %0d",
                         g, rq.size(), xq.size());
                break;
            end
        end
        stall_v[g] = 1'b0;
        drive(g, 1'b0, ap, 1'b0, dp);
    endtask

    task automatic check_model(input int g);
        xfer_t x;
        bit    act, leg;
        int    widx, n;
        n = (rq.size() < xq.size()) ? rq.size() : xq.size();
        check("result_count", g, 32'(rq.size()), 32'(xq.size()));
        for (int i = 0; i < n; i++) begin
            x    = xq[i];
            act  = x.sel && x.trans[1];
            leg  = act && legal_m(x.size, x.addr);
            widx = int'((x.addr >> 2) % DEPTH);
            if (leg && !x.wr) last_m[g] = mem_m[g][widx];
            check("rnd_resp", i, 32'(rq[i].resp), 32'(act && !leg));
            check("rnd_waits", i, 32'(rq[i].waits), 32'(!act ? 0 : leg ? ws_of(g) : 1));
            check("rnd_err1_resp", i, 32'(rq[i].wresp), 32'(act && !leg));
            check("rnd_hrdata", i, rq[i].rdata, last_m[g]);
            if (leg && x.wr) begin
                for (int k = 0; k < 4; k++) begin
                    if (lane_m(x.size, x.addr, k)) mem_m[g][widx][8*k +: 8] = x.wdata[8*k +: 8];
                end
            end
        end
    endtask

    task automatic reset_all();
        for (int g = 0; g < NDUT; g++) rst_n[g] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) rst_n[g] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, j, g;
        xfer_t x;
        for (int k = 0; k < NDUT; k++) begin
            rst_n[k] = 1'b0; sel_v[k] = 1'b0; trans_v[k] = 2'b00; addr_v[k] = 32'h0;
            wr_v[k] = 1'b0; size_v[k] = 3'd0; burst_v[k] = 3'd0; prot_v[k] = 4'd0;
            lock_v[k] = 1'b0; wdata_v[k] = 32'h0; stall_v[k] = 1'b0;
        end

        // Directed vectors: {dut, transfer, check-read, read data, resp, wait cycles}.
        tab.push_back(mkv(0, mkx(2, 32'h2000_0010, 1, 2, 32'hDEAD_BEEF), 0, 0, 0, 0));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0010, 0, 2, 32'h0), 1, 32'hDEAD_BEEF, 0, 0));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0004, 1, 2, 32'h0000_0000), 0, 0, 0, 0));
        tab.push_back(mkv(0, mkx(3, 32'h2000_0005, 1, 0, 32'h0000_AA00), 0, 0, 0, 0));
        tab.push_back(mkv(0, mkx(3, 32'h2000_0006, 1, 1, 32'h1234_0000), 0, 0, 0, 0));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0004, 0, 2, 32'h0), 1, 32'h1234_AA00, 0, 0));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0000, 1, 2, 32'h0102_0304), 0, 0, 0, 0));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0002, 1, 2, 32'hFFFF_FFFF), 0, 0, 1, 1));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0000, 0, 2, 32'h0), 1, 32'h0102_0304, 0, 0));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0006, 0, 0, 32'h0), 1, 32'h1234_AA00, 0, 0));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0001, 0, 1, 32'h0), 0, 0, 1, 1));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0000, 1, 3, 32'h0BAD_0BAD), 0, 0, 1, 1));
        tab.push_back(mkv(0, mkx(1, 32'h2000_0000, 1, 2, 32'h0BAD_0BAD), 0, 0, 0, 0));
        tab.push_back(mkv(0, mkx(2, 32'h2000_0000, 0, 2, 32'h0), 1, 32'h0102_0304, 0, 0));
        tab.push_back(mkv(1, mkx(2, 32'h2000_0020, 1, 2, 32'hCAFE_F00D), 0, 0, 0, 3));
        tab.push_back(mkv(1, mkx(2, 32'h2000_0020, 0, 2, 32'h0), 1, 32'hCAFE_F00D, 0, 3));
        tab.push_back(mkv(1, mkx(2, 32'h2000_0003, 0, 1, 32'h0), 0, 0, 1, 1));
        tab.push_back(mkv(2, mkx(2, 32'h2000_0008, 1, 2, 32'h1111_2222), 0, 0, 0, 2));
        tab.push_back(mkv(2, mkx(2, 32'h2000_0008, 0, 2, 32'h0), 1, 32'h1111_2222, 0, 2));

        reset_all();
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("reset_hreadyout", k, 32'(ro_v[k]), 32'd1);
            check("reset_hresp", k, 32'(resp_v[k]), 32'd0);
            check("reset_hrdata", k, rd_v[k], 32'h0);
        end
        @(posedge clk);
        #1;

        i = 0;
        while (i < tab.size()) begin
            g = tab[i].g;
            xq.delete();
            j = i;
            while (j < tab.size() && tab[j].g == g) begin
                xq.push_back(tab[j].x);
                j++;
            end
            run_stream(g);
            for (int k = i; k < j; k++) begin
                if (k - i < rq.size()) begin
                    check("vec_resp", k, 32'(rq[k-i].resp), 32'(tab[k].exp_resp));
                    check("vec_waits", k, 32'(rq[k-i].waits), 32'(tab[k].exp_waits));
                    check("vec_err1_resp", k, 32'(rq[k-i].wresp), 32'(tab[k].exp_resp));
                    if (tab[k].chk) check("vec_hrdata", k, rq[k-i].rdata, tab[k].exp_rd);
                end else begin
                    check("vec_missing", k, 32'(rq.size()), 32'(j - i));
                end
            end
            i = j;
        end

        // Another slave holds hready low: a presented write must not be accepted.
        sel_v[0] = 1'b1; trans_v[0] = 2'b10; addr_v[0] = 32'h2000_0010; wr_v[0] = 1'b1;
        size_v[0] = 3'd2; wdata_v[0] = 32'h0; stall_v[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stall_hreadyout", 0, 32'(ro_v[0]), 32'd1);
            check("stall_hresp", 0, 32'(resp_v[0]), 32'd0);
            check("stall_hrdata", 0, rd_v[0], 32'h0102_0304);
            @(posedge clk);
            #1;
        end
        sel_v[0] = 1'b0; trans_v[0] = 2'b00; stall_v[0] = 1'b0;
        xq.delete();
        xq.push_back(mkx(2, 32'h2000_0010, 0, 2, 32'h0));
        run_stream(0);
        check("stall_no_write", 0, (rq.size() > 0) ? rq[0].rdata : 32'hx, 32'hDEAD_BEEF);

        // Reset during the first wait cycle of a write on the 2-wait-state instance.
        sel_v[2] = 1'b1; trans_v[2] = 2'b10; addr_v[2] = 32'h2000_0008; wr_v[2] = 1'b1;
        size_v[2] = 3'd2;
        @(posedge clk);
        #1;
        sel_v[2] = 1'b0; trans_v[2] = 2'b00; wdata_v[2] = 32'h5555_5555; rst_n[2] = 1'b0;
        @(negedge clk);
        check("midwrite_wait", 2, 32'(ro_v[2]), 32'd0);
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        @(negedge clk);
        check("midreset_hreadyout", 2, 32'(ro_v[2]), 32'd1);
        check("midreset_hresp", 2, 32'(resp_v[2]), 32'd0);
        check("midreset_hrdata", 2, rd_v[2], 32'h0);
        @(posedge clk);
        #1;
        xq.delete();
        xq.push_back(mkx(2, 32'h2000_0008, 0, 2, 32'h0));
        run_stream(2);
        check("midreset_no_write", 2, (rq.size() > 0) ? rq[0].rdata : 32'hx, 32'h1111_2222);

        // Randomized pipelined traffic against the transaction-level model.
        reset_all();
        stall_en = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            last_m[d] = 32'h0;
            xq.delete();
            for (int w = 0; w < int'(DEPTH); w++) begin
                x = mkx(2, ($urandom & 32'hFFFF_FFC0) | 32'(w * 4), 1, 2, $urandom);
                xq.push_back(x);
            end
            run_stream(d);
            check_model(d);
            xq.delete();
            for (int n = 0; n < 150; n++) begin
                int t;
                logic [31:0] low;
                x.sel   = ($urandom_range(7) != 0);
                t       = int'($urandom_range(9));
                x.trans = (t == 0) ? 2'b00 : (t == 1) ? 2'b01 : (t < 6) ? 2'b10 : 2'b11;
                x.size  = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 3))
                                                   : 3'($urandom_range(2));
                low     = 32'($urandom_range(DEPTH * 4 - 1));
                if ($urandom_range(1) == 1 && x.size <= 3'd2) low = low & ~((32'd1 << x.size) - 1);
                x.addr  = ($urandom & ~32'(DEPTH * 4 - 1)) | low;
                x.wr    = 1'($urandom_range(1));
                x.wdata = $urandom;
                xq.push_back(x);
            end
            run_stream(d);
            check_model(d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hasti_sram_slave.md
# hasti_sram_slave

AHB-Lite (HASTI) responder wrapping a word-organised, byte-writable on-chip SRAM. It is one of the slave ports behind the HASTI bus decoder/multiplexer, for example the SRAM window at 0x20000000–0x200003FF. It decodes address and data phases, inserts a configurable number of wait states, returns a two-cycle ERROR for illegal transfers, and forwards write data to a back-to-back read of the same word.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words. Power of two, ≥2. Word index is haddr[$clog2(DEPTH_WORDS)+1:2]; higher address bits are ignored.
- WAIT_STATES, 0: wait cycles (hreadyout=0) inserted in every OKAY data phase; 0..15.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- hclk  in  1  bus clock, all state on rising edge
- hresetn  in  1  synchronous active-low reset
- hsel  in  1  slave select from bus decoder
- haddr  in  32  byte address
- hwrite  in  1  1=write
- hsize  in  3  0=byte, 1=halfword, 2=word
- hburst  in  3  ignored (every beat is treated as a single transfer)
- hprot  in  4  ignored
- htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- hmastlock  in  1  ignored
- hwdata  in  32  write data, valid in data phase
- hready  in  1  bus-level ready (muxed hreadyout)
- hrdata  out  32  read data
- hreadyout  out  1  this slave's ready
- hresp  out  1  0=OKAY, 1=ERROR

## Operation
- Accept: an address phase is accepted on a rising edge with hsel=1, hready=1 and htrans[1]=1. It registers the word index, byte offset, hsize and hwrite. No acceptance occurs while hready=0.
- Legality, checked at acceptance:
  - hsize>2 is illegal.
  - hsize=1 with haddr[0]=1 is illegal.
  - hsize=2 with haddr[1:0]≠0 is illegal.
- Byte lanes: little-endian. Byte k = hwdata/hrdata[8k+7:8k]. A byte access enables lane haddr[1:0]. A halfword enables lanes {haddr[1],0}+{0,1}. A word enables all four lanes.
- State machine, tracking the data phase:
  - IDLE: no data phase. hreadyout=1, hresp=0.
  - Legal accept with WAIT_STATES=0: stay in IDLE-equivalent completion (single-cycle data phase).
  - Legal accept with WAIT_STATES>0: go to WAIT with counter=WAIT_STATES. In WAIT, hreadyout=0 and the counter decrements each cycle. When it reaches 0, hreadyout=1 for one cycle (completion).
  - Illegal accept: go to ERR1, then ERR2, then the next state. ERR1 drives hreadyout=0, hresp=1. ERR2 drives hreadyout=1, hresp=1.
  - A new acceptance in the completion or ERR2 cycle starts the next data phase directly.
- Selected IDLE/BUSY transfers: zero-wait OKAY, no memory access.
- Write: the enabled lanes of hwdata are committed to the array on the completion edge of a legal write data phase. Illegal writes never modify the array.
- Read: hrdata is registered at the acceptance edge from the array word.
  - Forwarding: if that same edge commits a write to the same word, the committed bytes replace the array bytes in hrdata.
  - hrdata holds until the next legal read is accepted. It is not zeroed between reads or during writes/errors.
- Array contents are not initialised and not affected by reset.

## Timing
- Reset (hresetn=0 at an edge):
  - State becomes IDLE, counter 0, hreadyout=1, hresp=0, hrdata=0.
  - Any in-flight write is dropped with no array update.
  - Registered address-phase information is cleared.
- Data phase latency: legal read/write = WAIT_STATES+1 cycles after the acceptance edge. Error = exactly 2 cycles.
- Pipelining: with WAIT_STATES=0, back-to-back transfers complete one per cycle, including write-then-read of the same address, which returns the new data through forwarding.
- hresp=1 only in ERR1/ERR2. hreadyout=0 only in WAIT or ERR1.
- hready=0 caused by another slave while this block is IDLE: no acceptance, outputs unchanged.
- Reset asserted mid-WAIT or mid-ERR: the next cycle shows IDLE outputs. The interrupted write is not committed.

## Test plan
- Reset: hold hresetn=0 for 2 cycles, then release. Required: hreadyout=1, hresp=0, hrdata=0x00000000.
- WAIT_STATES=0, back-to-back pipelined transfers:
  - Stimulus: word write 0xDEADBEEF to 0x20000010, then word read of 0x20000010 in the very next address phase.
  - Required: hreadyout never 0; read data 0xDEADBEEF (forwarded).
- Byte/halfword writes to one word:
  - Stimulus: word write 0x00000000 to 0x04, then byte write 0xAA to 0x05 (hwdata=0x0000AA00), then halfword write 0x1234 to 0x06 (hwdata=0x12340000), then word read of 0x04.
  - Required: read returns 0x1234AA00.
- Misaligned access:
  - Stimulus: word write to 0x02 with hwdata=0xFFFFFFFF.
  - Required: hreadyout=0/hresp=1, then hreadyout=1/hresp=1; a subsequent read of 0x00 returns its prior value unchanged.
- WAIT_STATES=3 read:
  - Required: hreadyout low for exactly 3 cycles after acceptance, high on the 4th cycle with correct hrdata and hresp=0.
- WAIT_STATES=2 reset mid-write:
  - Stimulus: assert hresetn=0 during the first wait cycle of a write of 0x55555555 to 0x08.
  - Required: the next cycle shows hreadyout=1, hresp=0; a later read of 0x08 returns its old value.
